// File: rtl/spi_mpu_pkg.sv
// spi_mpu_pkg: shared frame constants and state encoding for the SPI MPU responder.
package spi_mpu_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 8;
    localparam logic RW_READ = 1'b1;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detect on the last two synchronized samples.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sh;
    logic prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= {SYNC_STAGES{INIT}};
            prev <= INIT;
        end else begin
            sh <= {sh[SYNC_STAGES-2:0], din};
            prev <= sh[SYNC_STAGES-1];
        end
    end
    assign q = sh[SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_mpu_slave.sv
// spi_mpu_slave: CPOL=1/CPHA=1 SPI responder for R/W + 7-bit address + data-byte frames.
// Define SPI_MPU_SLAVE_BURST_EN to keep streaming bytes at incrementing addresses while ss_n stays low.
module spi_mpu_slave
    import spi_mpu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS = spi_mpu_pkg::FRAME_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss_n,
    input  logic                 sclk,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [DATA_BITS-1:0] wr_data,
    output logic                 frame_done
);
    localparam logic [3:0] ADDR_LAST = 4'(FRAME_BITS / 2 - 1);
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);
    logic sclk_q, sclk_rise, sclk_fall, mosi_q, mosi_rise, mosi_fall, ss_q, ss_rise, ss_fall;
    logic unused_edges;
    state_t state;
    logic [3:0] cnt;
    logic [DATA_BITS-1:0] rx, tx, rx_next;
    logic [ADDR_BITS-1:0] addr;
    logic rw, rise_ev, fall_ev;
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
        .clk(clk), .rst(rst), .din(ss_n), .q(ss_q), .rise(ss_rise), .fall(ss_fall));
    assign unused_edges = ^{sclk_q, mosi_rise, mosi_fall, ss_rise, ss_fall};
    // sclk edges only count while the chip is selected in that same cycle
    assign rise_ev = sclk_rise & ~ss_q;
    assign fall_ev = sclk_fall & ~ss_q;
    assign rx_next = {rx[DATA_BITS-2:0], mosi_q};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            rx <= '0;
            tx <= '0;
            addr <= '0;
            rw <= 1'b0;
            miso <= 1'b0;
            miso_oe <= 1'b0;
            rd_en <= 1'b0;
            rd_addr <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            frame_done <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            frame_done <= 1'b0;
            if (rd_en) tx <= rd_data;
            if (state != IDLE && ss_q) begin
                state <= IDLE;
                miso <= 1'b0;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        miso <= 1'b0;
                        miso_oe <= 1'b0;
                        if (!ss_q) state <= ADDR;
                    end
                    ADDR: if (rise_ev) begin
                        rx <= rx_next;
                        cnt <= cnt + 4'd1;
                        if (cnt == ADDR_LAST) begin
                            addr <= rx_next[ADDR_BITS-1:0];
                            rw <= rx_next[DATA_BITS-1];
                            state <= DATA;
                            if (rx_next[DATA_BITS-1] == RW_READ) begin
                                rd_en <= 1'b1;
                                rd_addr <= rx_next[ADDR_BITS-1:0];
                                miso_oe <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (fall_ev && rw == RW_READ) begin
                            miso <= tx[DATA_BITS-1];
                            tx <= {tx[DATA_BITS-2:0], 1'b0};
                        end
                        if (rise_ev) begin
                            rx <= rx_next;
                            cnt <= cnt + 4'd1;
                            if (cnt == FRAME_LAST) begin
                                frame_done <= 1'b1;
                                if (rw != RW_READ) begin
                                    wr_en <= 1'b1;
                                    wr_addr <= addr;
                                    wr_data <= rx_next;
                                end
`ifdef SPI_MPU_SLAVE_BURST_EN
                                cnt <= ADDR_LAST + 4'd1;
                                addr <= addr + 1'b1;
                                if (rw == RW_READ) begin
                                    rd_en <= 1'b1;
                                    rd_addr <= addr + 1'b1;
                                end
`else
                                cnt <= cnt;
                                state <= DONE;
`endif
                            end
                        end
                    end
                    DONE: cnt <= cnt;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_mpu_slave.sv
// tb_spi_mpu_slave: table-driven and randomized frames against a register-file reference model.
module tb_spi_mpu_slave;
    localparam int HALF = 8;
    logic clk = 1'b0, rst = 1'b1, ss_n = 1'b1, sclk = 1'b1, mosi = 1'b0, load = 1'b1;
    logic miso, miso_oe, rd_en, wr_en, frame_done;
    logic [6:0] rd_addr, wr_addr;
    logic [7:0] rd_data, wr_data;
    logic [7:0] mem [128];
    logic [7:0] exp_mem [128];
    int n_wr = 0, n_rd = 0, n_done = 0, n_oe = 0, n_bad = 0;
    logic [14:0] last_wr = '0;
    logic [6:0] last_rd = '0;
    logic [6:0] rd_hist [$];
    int errors = 0, checks = 0;

    spi_mpu_slave dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done));

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return (i == 'h75) ? 8'h71 : 8'(i * 3 + 1);
    endfunction

    // register file the responder talks to
    always @(posedge clk) begin
        if (load) for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
        else if (wr_en) mem[wr_addr] <= wr_data;
    end
    assign rd_data = mem[rd_addr];

    always @(negedge clk) begin
        if (wr_en) begin n_wr++; last_wr = {wr_addr, wr_data}; end
        if (rd_en) begin n_rd++; last_rd = rd_addr; rd_hist.push_back(rd_addr); end
        if (frame_done) n_done++;
        if (miso_oe) n_oe++;
        if (miso && !miso_oe) n_bad++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [31:0] w, input int n, output logic [23:0] rb);
        rb = '0;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            mosi = w[31-i];
            repeat (HALF) @(negedge clk);
            if (i >= 8) rb = {rb[22:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic spi_frame(input logic [31:0] w, input int n, output logic [23:0] rb);
        @(negedge clk);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(w, n, rb);
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] frame;
        int nbits;
        int n_wr;
        int n_rd;
        int n_done;
        logic [7:0] miso_b;
    } vec_t;
    vec_t vecs [9];

    initial begin
        int b_wr, b_rd, b_done, b_oe, base;
        logic [23:0] rb;
        logic [6:0] a;
        logic [7:0] d;
        logic r;
        vecs[0] = '{16'hF500, 16, 0, 1, 1, 8'h71};
        vecs[1] = '{16'h6B80, 16, 1, 0, 1, 8'h00};
        vecs[2] = '{16'h1A03, 11, 0, 0, 0, 8'h00};
        vecs[3] = '{16'hF500, 16, 0, 1, 1, 8'h71};
        vecs[4] = '{16'h2211, 16, 1, 0, 1, 8'h00};
        vecs[5] = '{16'h3344, 16, 1, 0, 1, 8'h00};
        vecs[6] = '{16'hA200, 16, 0, 1, 1, 8'h11};
        vecs[7] = '{16'h4C5D, 20, 1, 0, 1, 8'h00};
        vecs[8] = '{16'hCC00, 16, 0, 1, 1, 8'h5D};
        for (int i = 0; i < 128; i++) exp_mem[i] = init_val(i);
        repeat (4) @(negedge clk);
        load = 1'b0;
        chk("rst_outputs", {miso, miso_oe, rd_en, wr_en, frame_done}, 5'b0);
        chk("rst_addrs", {rd_addr, wr_addr, wr_data}, 22'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int v = 0; v < 9; v++) begin
            b_wr = n_wr; b_rd = n_rd; b_done = n_done; b_oe = n_oe;
            spi_frame({vecs[v].frame, 16'h0}, vecs[v].nbits, rb);
            chk($sformatf("v%0d_wr_cnt", v), n_wr - b_wr, vecs[v].n_wr);
            chk($sformatf("v%0d_rd_cnt", v), n_rd - b_rd, vecs[v].n_rd);
            chk($sformatf("v%0d_done_cnt", v), n_done - b_done, vecs[v].n_done);
            if (vecs[v].n_rd != 0) begin
                chk($sformatf("v%0d_rd_addr", v), last_rd, vecs[v].frame[14:8]);
                chk($sformatf("v%0d_miso", v), rb[7:0], vecs[v].miso_b);
            end
            if (vecs[v].n_wr != 0) begin
                chk($sformatf("v%0d_wr", v), last_wr, vecs[v].frame[14:0]);
                exp_mem[vecs[v].frame[14:8]] = vecs[v].frame[7:0];
            end
            if (!vecs[v].frame[15]) chk($sformatf("v%0d_oe_low", v), n_oe - b_oe, 0);
        end
        // wr_en timing relative to the last physical rising sclk edge
        @(negedge clk);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits({16'h5A3C, 16'h0}, 15, rb);
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        @(negedge clk); chk("lat_c1", wr_en, 1'b0);
        @(negedge clk); chk("lat_c2", wr_en, 1'b0);
        @(negedge clk); chk("lat_c3", {wr_en, wr_addr, wr_data}, {1'b1, 7'h5A, 8'h3C});
        @(negedge clk); chk("lat_c4", wr_en, 1'b0);
        exp_mem[7'h5A] = 8'h3C;
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        // reset in the middle of a read data phase
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits({16'hF500, 16'h0}, 10, rb);
        chk("mid_oe", miso_oe, 1'b1);
        b_wr = n_wr; b_done = n_done;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", {miso, miso_oe, rd_en, wr_en, frame_done}, 5'b0);
        ss_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4 * HALF) @(negedge clk);
        chk("rst_mid_pulses", (n_wr - b_wr) + (n_done - b_done), 0);
        spi_frame({16'hF500, 16'h0}, 16, rb);
        chk("post_rst_read", rb[7:0], 8'h71);
        // randomized frames against the register-file model
        for (int k = 0; k < 16; k++) begin
            r = 1'($urandom_range(0, 1));
            a = 7'($urandom_range(0, 127));
            d = 8'($urandom);
            b_wr = n_wr; b_rd = n_rd; b_done = n_done;
            spi_frame({r, a, d, 16'h0}, 16, rb);
            chk($sformatf("r%0d_done", k), n_done - b_done, 1);
            if (r) begin
                chk($sformatf("r%0d_rd", k), {n_rd - b_rd, 25'(last_rd)}, {32'd1, 25'(a)});
                chk($sformatf("r%0d_miso", k), rb[7:0], exp_mem[a]);
            end else begin
                chk($sformatf("r%0d_wr", k), {n_wr - b_wr, 17'(last_wr)}, {32'd1, 17'({a, d})});
                exp_mem[a] = d;
            end
        end
`ifdef SPI_MPU_SLAVE_BURST_EN
        base = rd_hist.size();
        b_done = n_done;
        spi_frame({8'hFF, 24'h0}, 32, rb);
        chk("burst_rd_cnt", rd_hist.size() >= base + 3, 1'b1);
        if (rd_hist.size() >= base + 3) begin
            chk("burst_a0", rd_hist[base], 7'h7F);
            chk("burst_a1", rd_hist[base+1], 7'h00);
            chk("burst_a2", rd_hist[base+2], 7'h01);
        end
        chk("burst_done", n_done - b_done, 3);
        chk("burst_data", rb, {exp_mem[7'h7F], exp_mem[7'h00], exp_mem[7'h01]});
`else
        base = 0;
`endif
        chk("miso_gated", n_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_mpu_slave.md
Name: spi_mpu_slave

Overview:
SPI responder for the MPU register-access protocol. It answers 16-bit frames from the team's SPI MPU master with CPOL=1 and CPHA=1. It serves as a sensor stand-in for system bring-up and loopback tests, and as a host-side register port. The block oversamples sclk, mosi and ss_n in the clk domain and decodes a R/W bit plus a 7-bit address. On reads it shifts out a byte fetched through a register-file interface; on writes it commits the received byte.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on sclk, mosi and ss_n (minimum 2).
FRAME_BITS, 16, bits per frame; fixed at 16 (1 R/W + 7 addr + 8 data), exposed for package consistency.

Ports:
clk  in  1  system clock; frequency must be at least 8x the sclk frequency.
rst  in  1  synchronous, active-high reset.
ss_n  in  1  chip select, active low, asynchronous to clk.
sclk  in  1  SPI clock, idle high, asynchronous to clk.
mosi  in  1  master data out; driven on sclk falling edges.
miso  out  1  slave data out; updated after sclk falling edges.
miso_oe  out  1  high while a read data phase is active; for the top-level tristate.
rd_en  out  1  one-cycle pulse requesting register rd_addr.
rd_addr  out  7  read address; held until the frame ends.
rd_data  in  8  register value; must be valid on the clk edge after rd_en.
wr_en  out  1  one-cycle write-commit pulse.
wr_addr  out  7  write address; valid with wr_en.
wr_data  out  8  write data; valid with wr_en.
frame_done  out  1  one-cycle pulse on a complete 16-bit frame.

Behaviour:
- Reset: all outputs 0; state IDLE; bit counter 0; shift registers 0.
- Inputs pass through SYNC_STAGES flops. Edge detect compares the last two synchronized sclk samples.
  - A rise or fall event counts only if synchronized ss_n is low in the same cycle.
- mosi is sampled on each sclk rising event and shifted in MSB first. Bit 15 is R/W: 1 = read, 0 = write.
- States:
  - IDLE: wait for synchronized ss_n low, then go to ADDR. Clear the counter and miso.
  - ADDR: count 8 rising events. On the 8th, latch the addr and rw flag, then go to DATA.
    - Read: pulse rd_en with rd_addr in the same cycle, capture rd_data one cycle later into the tx shift register, and assert miso_oe.
  - DATA, read: on each of the next 8 falling events, miso takes the next tx bit, MSB first. The first falling event after the address byte presents bit 7. mosi bits are still shifted in and ignored.
  - DATA, write: 8 rising events shift in data. On the 8th, pulse wr_en with wr_addr/wr_data and go to DONE.
  - DATA, read, 8th rising event: go to DONE.
  - DONE: pulse frame_done for one cycle; miso is held until ss_n rises; then go to IDLE. Extra sclk edges are ignored.
- miso is 0 whenever miso_oe is 0.
- Boundaries:
  - ss_n rises mid-frame: return to IDLE next cycle. No wr_en, no frame_done; miso and miso_oe go to 0.
  - ss_n rise and the 16th rising event synchronized in the same cycle: the edge is not counted, so the frame is aborted.
  - rst mid-frame: immediate return to IDLE. Any pending wr_en is suppressed.
  - Bit counter is 4 bits and never wraps within a frame; it saturates in DONE.
- Latency: wr_en arrives SYNC_STAGES+1 clk cycles after the 16th physical rising sclk edge.

Optional Feature:
SPI_MPU_SLAVE_BURST_EN
- Defined: instead of DONE, the frame continues while ss_n stays low. Each further 8 bits:
  - read: rd_addr increments (wraps 0x7F to 0x00), with a new rd_en/rd_data fetch before the next byte's first falling event.
  - write: wr_en is pulsed at an incremented wr_addr.
  - frame_done pulses per byte.
- Undefined: single-byte frames only, as described above.

Decomposition:
- Package spi_mpu_pkg holds:
  - state enum (IDLE, ADDR, DATA, DONE);
  - FRAME_BITS, ADDR_BITS=7, DATA_BITS=8;
  - RW_READ=1'b1.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect per input, reused for sclk, mosi and ss_n.

Test Plan:
- Read WHO_AM_I: frame 0xF5xx, with rd_data model returning 0x71 for addr 0x75. Expect one rd_en with rd_addr=0x75, miso bits 0x71 MSB first, one frame_done, no wr_en.
- Write PWR_MGMT_1: frame 0x6B80. Expect one wr_en with wr_addr=0x6B, wr_data=0x80, frame_done, and miso_oe low throughout.
- Abort: ss_n rises after 11 bits of 0x1A03. Expect no wr_en, no frame_done, and a clean read of 0x75 on the next frame.
- Back-to-back frames: two writes with 2 idle sclk periods between. Expect exactly two wr_en pulses with the correct address/data pairs.
- Reset mid-read after 10 bits: miso, miso_oe and all pulses go to 0; the next frame decodes correctly.
- Burst (SPI_MPU_SLAVE_BURST_EN): read at 0x7F for 3 bytes. Expect rd_addr sequence 0x7F, 0x00, 0x01 and three frame_done pulses.
